// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access paths (load extend, store merge).
package mem_pkg;

    // Access size encodings as carried on the pipeline's size field.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Store sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // True when the size is illegal or the address is not naturally aligned.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational little-endian merge of store data into an existing memory word.
module lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_word
);

    // Overwrite only the addressed lanes; every other lane keeps the old word.
    always_comb begin
        // NOTE: default assigned first so no path leaves o_word unassigned (no latch).
        o_word = i_old;
        case (i_size)
            SZ_BYTE: o_word[{i_lane, 3'b000} +: 8]     = i_data[7:0];
            SZ_HALF: o_word[{i_lane[1], 4'b0000} +: 16] = i_data[15:0];
            SZ_WORD: o_word = i_data;
            default: o_word = i_old;
        endcase
    end

endmodule

// File: rtl/subword_store.sv
// Store unit: byte/half stores into word-only memory by read-modify-write.
module subword_store
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        done,
    output logic        err,
    output logic [29:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_data;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_done;
    logic        r_err;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [29:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] w_merged;
    logic        w_accept;
    logic        w_bad;
    logic        w_capture;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_bad     = is_bad_access(req_size, req_addr[1:0]);
    assign w_capture = ((r_state == ST_RD) || (r_state == ST_RWAIT)) && mem_rvalid;

    lane_merge u_lane_merge (
        .i_old  (mem_rdata),
        .i_data (r_data),
        .i_size (r_size),
        .i_lane (r_lane),
        .o_word (w_merged)
    );

    // Next-state logic; memory handshakes only matter in the states waiting on them.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_bad)                    w_next = ST_FIN;
                    else if (req_size == SZ_WORD) w_next = ST_WR;
                    else                          w_next = ST_RD;
                end
            end
            ST_RD:    w_next = mem_rvalid ? ST_WR : ST_RWAIT;
            ST_RWAIT: if (mem_rvalid) w_next = ST_WR;
            ST_WR:    if (mem_wack) w_next = ST_FIN;
            ST_FIN:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Request fields are sampled only on accept, so they hold through the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_size <= SZ_BYTE;
            r_lane <= 2'b00;
        end else if (w_accept) begin
            r_data <= req_data;
            r_size <= req_size;
            r_lane <= req_addr[1:0];
        end
    end

    // Registered strobes derived from the state being entered next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mem_rd <= (w_next == ST_RD);
            r_mem_wr <= (w_next == ST_WR);
            r_done   <= (w_next == ST_FIN);
            r_err    <= w_accept && w_bad;
        end
    end

    // Memory address/data: loaded on accept, write word replaced by the merge on read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_mem_addr <= req_addr[31:2];
            end
            if (w_accept && !w_bad && (req_size == SZ_WORD)) begin
                r_mem_wdata <= req_data;
            end else if (w_capture) begin
                r_mem_wdata <= w_merged;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_subword_store.sv
// Directed self-checking bench for subword_store.
module tb_subword_store;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    int total;
    int bad;

    subword_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One store from accept to done, with a bench-side memory responder.
    task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input logic [31:0] mem_word,
                             input int rd_delay, input int wr_delay,
                             input logic [31:0] exp_wdata, input logic exp_err,
                             input int exp_lat, input bit hold);
        int cyc;
        int rd_seen;
        int wr_first;
        int rd_cnt;
        int wr_cnt;
        int done_cyc;
        check({tag, ".ready_before"}, {31'b0, req_ready}, 32'd1);
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        req_valid = 1'b1;
        cyc = 0; rd_seen = -1; wr_first = -1; rd_cnt = 0; wr_cnt = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 40) begin
            step();
            cyc++;
            if (!hold) req_valid = 1'b0;
            mem_rvalid = 1'b0;
            mem_wack   = 1'b0;
            mem_rdata  = 32'h0;
            if (mem_rd) begin
                rd_cnt++;
                rd_seen = cyc;
            end
            if (rd_seen >= 0 && cyc == rd_seen + rd_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word;
            end
            if (mem_wr) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = cyc;
                check({tag, ".wdata"}, mem_wdata, exp_wdata);
                check({tag, ".maddr"}, {2'b00, mem_addr}, {2'b00, addr[31:2]});
                if (cyc == wr_first + wr_delay) mem_wack = 1'b1;
            end
            if (done) done_cyc = cyc;
        end
        check({tag, ".done_seen"}, {31'b0, (done_cyc >= 0)}, 32'd1);
        check({tag, ".latency"}, done_cyc, exp_lat);
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, ".ready_in_done"}, {31'b0, req_ready}, 32'd0);
        check({tag, ".rd_pulses"}, rd_cnt, (exp_err || size == 2'd2) ? 0 : 1);
        check({tag, ".wr_cycles"}, wr_cnt, exp_err ? 0 : wr_delay + 1);
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
        step();
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, ".ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_data   = 32'h0;
        req_size   = 2'd0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.done",  {31'b0, done}, 32'd0);
        check("rst.err",   {31'b0, err}, 32'd0);
        check("rst.rd",    {31'b0, mem_rd}, 32'd0);
        check("rst.wr",    {31'b0, mem_wr}, 32'd0);
        check("rst.addr",  {2'b00, mem_addr}, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Word store, zero wait: done at T2.
        run_store("word", 32'h100, 32'hDEADBEEF, 2'd2, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

        // Byte stores into each lane, zero wait: done at T3.
        run_store("byte3", 32'h103, 32'h000000AB, 2'd0, 32'h11223344, 0, 0, 32'hAB223344, 1'b0, 3, 1'b0);
        run_store("byte0", 32'h100, 32'h000000AB, 2'd0, 32'h11223344, 0, 0, 32'h112233AB, 1'b0, 3, 1'b0);
        run_store("byte1", 32'h101, 32'h000000AB, 2'd0, 32'h11223344, 0, 0, 32'h1122AB44, 1'b0, 3, 1'b0);
        run_store("byte2", 32'h102, 32'h000000AB, 2'd0, 32'h11223344, 0, 0, 32'h11AB3344, 1'b0, 3, 1'b0);

        // Half stores: low half zero wait, high half with rvalid +3 and wack +2.
        run_store("half0", 32'h200, 32'hFFFF1234, 2'd1, 32'hAABBCCDD, 0, 0, 32'hAABB1234, 1'b0, 3, 1'b0);
        run_store("half2", 32'h202, 32'hFFFF1234, 2'd1, 32'hAABBCCDD, 3, 2, 32'h1234CCDD, 1'b0, 8, 1'b0);

        // Misaligned and illegal: done+err at T1, no memory strobes.
        run_store("mis_half", 32'h201, 32'h5555AAAA, 2'd1, 32'h0, 0, 0, 32'h0, 1'b1, 1, 1'b0);
        run_store("mis_word", 32'h102, 32'h5555AAAA, 2'd2, 32'h0, 0, 0, 32'h0, 1'b1, 1, 1'b0);
        run_store("ill_size", 32'h100, 32'h5555AAAA, 2'd3, 32'h0, 0, 0, 32'h0, 1'b1, 1, 1'b0);

        // Reset while waiting for read data.
        req_addr  = 32'h300;
        req_data  = 32'h00000077;
        req_size  = 2'd0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("rwait.rd_t1", {31'b0, mem_rd}, 32'd1);
        step();
        check("rwait.rd_t2", {31'b0, mem_rd}, 32'd0);
        check("rwait.busy", {31'b0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rwait.rst_ready", {31'b0, req_ready}, 32'd1);
        check("rwait.rst_wr",    {31'b0, mem_wr}, 32'd0);
        check("rwait.rst_addr",  {2'b00, mem_addr}, 32'd0);
        check("rwait.rst_wdata", mem_wdata, 32'd0);
        check("rwait.rst_done",  {31'b0, done}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        step();
        check("rwait.hold_wr", {31'b0, mem_wr}, 32'd0);
        #2 rst_n = 1'b1;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("rwait.post_wr", {31'b0, mem_wr}, 32'd0);
        check("rwait.post_rd", {31'b0, mem_rd}, 32'd0);
        run_store("after_rst", 32'h304, 32'h0000BEEF, 2'd1, 32'h01020304, 1, 1, 32'h0102BEEF, 1'b0, 5, 1'b0);

        // Spurious write acks while idle must not trigger anything.
        mem_wack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("spur.wr", {31'b0, mem_wr}, 32'd0);
            check("spur.ready", {31'b0, req_ready}, 32'd1);
        end
        mem_wack = 1'b0;

        // Back-to-back requests with req_valid held high.
        run_store("b2b_word", 32'h400, 32'h0BADF00D, 2'd2, 32'h0, 0, 1, 32'h0BADF00D, 1'b0, 3, 1'b1);
        run_store("b2b_byte", 32'h405, 32'h000000EE, 2'd0, 32'h99887766, 0, 0, 32'h9988EE66, 1'b0, 3, 1'b1);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b.idle_wr", {31'b0, mem_wr}, 32'd0);
            check("b2b.idle_rd", {31'b0, mem_rd}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
